// File: rtl/snake_vga_pkg.sv
// Shared constants and types for the snake VGA tile pipeline: screen geometry,
// tile codes and the RAM scheduler state encoding.
package snake_vga_pkg;

  localparam int H_TILES   = 40;
  localparam int TILE_LOG2 = 4;
  localparam int V_ACTIVE  = 480;
  localparam int V_LAST    = 524;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BODY  = 2'd1,
    HEAD  = 2'd2,
    APPLE = 2'd3
  } tile_code_e;

  typedef enum logic {
    ST_RENDER = 1'b0,
    ST_GRANT  = 1'b1
  } sched_state_e;

  // True on the single pixel-enabled cycle that starts the given line.
  function automatic logic line_start(input logic p_tick, input logic [9:0] x,
                                      input logic [9:0] y, input logic [9:0] line);
    return p_tick && (y == line) && (x == 10'd0);
  endfunction

endpackage

// File: rtl/tile_ram_scheduler_if.sv
// Bundle of VGA timing, game-side and RAM-side signals around the scheduler.
// slave = the scheduler itself, master = whoever drives timing and game inputs.
interface tile_ram_scheduler_if #(
  parameter int ADDR_W  = 11,
  parameter int TILE_W  = 2,
  parameter int SPEED_W = 4
) ();

  logic              p_tick;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              video_on;
  logic [SPEED_W-1:0] speed;
  logic              pause;
  logic [ADDR_W-1:0] game_addr;
  logic              game_we;
  logic [TILE_W-1:0] game_wdata;
  logic              game_done;
  logic              step;
  logic              game_gnt;
  logic              overrun;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [TILE_W-1:0] ram_wdata;

  modport slave (
    input  p_tick, x, y, video_on, speed, pause,
    input  game_addr, game_we, game_wdata, game_done,
    output step, game_gnt, overrun, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output p_tick, x, y, video_on, speed, pause,
    output game_addr, game_we, game_wdata, game_done,
    input  step, game_gnt, overrun, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/tile_ram_scheduler_addr_calc.sv
// Combinational pixel (x,y) to tile-RAM index; shared with the renderer.
module tile_addr_calc #(
  parameter int H_TILES   = 40,
  parameter int TILE_LOG2 = 4,
  parameter int ADDR_W    = 11
) (
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row_base;

  assign row = ADDR_W'(y >> TILE_LOG2);
  assign col = ADDR_W'(x >> TILE_LOG2);

  // 40 tiles per row is a shift-add, so no multiplier is needed on the default geometry.
  generate
    if (H_TILES == 40) begin : g_shift_add
      assign row_base = (row << 5) + (row << 3);
    end else begin : g_mult
      assign row_base = ADDR_W'(row * H_TILES);
    end
  endgenerate

  assign addr = row_base + col;

endmodule

// File: rtl/tile_ram_scheduler.sv
// Arbitrates the single-port tile RAM: renderer during video, game logic for
// one blanking window every speed+1 frames.
module tile_ram_scheduler
  import snake_vga_pkg::*;
#(
  parameter int H_TILES   = snake_vga_pkg::H_TILES,
  parameter int TILE_LOG2 = snake_vga_pkg::TILE_LOG2,
  parameter int ADDR_W    = 11,
  parameter int TILE_W    = 2,
  parameter int V_ACTIVE  = snake_vga_pkg::V_ACTIVE,
  parameter int V_LAST    = snake_vga_pkg::V_LAST,
  parameter int SPEED_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  tile_ram_scheduler_if.slave bus
);

  localparam logic [9:0] V_ACTIVE_Y = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST_Y   = 10'(V_LAST);

  sched_state_e       state_q, state_d;
  logic [SPEED_W-1:0] fcnt_q, fcnt_d;
  logic               step_q, step_d;
  logic               overrun_q, overrun_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic               ram_we_q, ram_we_d;
  logic [TILE_W-1:0]  ram_wdata_q, ram_wdata_d;

  logic              frame_end;
  logic              win_close;
  logic              gnt;
  logic [ADDR_W-1:0] render_addr;

  assign frame_end = line_start(bus.p_tick, bus.x, bus.y, V_ACTIVE_Y);
  assign win_close = line_start(bus.p_tick, bus.x, bus.y, V_LAST_Y);
  assign gnt       = (state_q == ST_GRANT);

  tile_addr_calc #(
    .H_TILES   (H_TILES),
    .TILE_LOG2 (TILE_LOG2),
    .ADDR_W    (ADDR_W)
  ) u_addr_calc (
    .x    (bus.x),
    .y    (bus.y),
    .addr (render_addr)
  );

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    step_d    = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      ST_RENDER: begin
        // fcnt may sit above a newly lowered speed; it then wraps through zero.
        if (frame_end && !bus.pause) begin
          if (fcnt_q == bus.speed) begin
            fcnt_d  = '0;
            step_d  = 1'b1;
            state_d = ST_GRANT;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      ST_GRANT: begin
        if (bus.game_done) begin
          state_d = ST_RENDER;
        end else if (win_close) begin
          overrun_d = 1'b1;
          state_d   = ST_RENDER;
        end
      end
      default: state_d = ST_RENDER;
    endcase
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = '0;
    if (gnt) begin
      ram_addr_d  = bus.game_addr;
      ram_we_d    = bus.game_we;
      ram_wdata_d = bus.game_wdata;
    end else if (bus.video_on) begin
      // Address is held through blanking to avoid needless toggling.
      ram_addr_d = render_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RENDER;
      fcnt_q      <= '0;
      step_q      <= 1'b0;
      overrun_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      step_q      <= step_d;
      overrun_q   <= overrun_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign bus.step      = step_q;
  assign bus.game_gnt  = gnt;
  assign bus.overrun   = overrun_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule
